// File: rtl/pwm_fade_pkg.sv
// Shared definitions for the PWM fade controller: default widths and FSM state codes.
package pwm_fade_pkg;

  localparam int DEF_R = 8;
  localparam int DEF_H = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_UP      = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_DOWN    = 3'd3,
    ST_HOLD_LO = 3'd4
  } fade_state_e;

endpackage

// File: rtl/pwm_period_tick.sv
// Free-running R-bit period counter; tick is high for the one clock the counter reads all ones.
module pwm_period_tick
  import pwm_fade_pkg::*;
#(
  parameter int R = DEF_R
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam logic [R-1:0] LAST = '1;

  logic [R-1:0] r_cnt;
  logic         r_tick;

  // Tick is registered one count early so it lines up exactly with r_cnt == LAST.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + R'(1);
      r_tick <= (r_cnt == LAST - R'(1));
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty-ramp controller: walks duty up to a ceiling, dwells, walks down to a floor, dwells, repeats.
module pwm_fade_ctrl
  import pwm_fade_pkg::*;
#(
  parameter int R = DEF_R,
  parameter int H = DEF_H
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [R-1:0] duty_min,
  input  logic [R-1:0] duty_max,
  input  logic [R-1:0] step,
  input  logic [H-1:0] hold_periods,
  output logic [R-1:0] duty,
  output logic         period_tick,
  output logic         busy,
  output logic         cycle_done,
  output logic [2:0]   state
);

  typedef struct packed {
    logic [R-1:0] min;
    logic [R-1:0] max_eff;
    logic [R-1:0] step_eff;
    logic [H-1:0] hold;
  } cfg_t;

  logic        w_tick;
  fade_state_e r_state,    w_state_nxt;
  logic [R-1:0] r_duty,    w_duty_nxt;
  logic [H-1:0] r_hold_cnt, w_hold_nxt;
  cfg_t        r_cfg,      w_cfg_nxt, w_cfg_new;
  logic        r_cycle_done, w_done_nxt;
  logic [R:0]  w_up_sum, w_dn_floor;

  pwm_period_tick #(.R(R)) u_period_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (w_tick)
  );

  // Config as it would be captured now; only committed on a latch event.
  always_comb begin
    w_cfg_new.min      = duty_min;
    w_cfg_new.max_eff  = (duty_max > duty_min) ? duty_max : duty_min;
    w_cfg_new.step_eff = (step == '0) ? R'(1) : step;
    w_cfg_new.hold     = hold_periods;
  end

  // One extra bit so the clamp comparisons cannot wrap.
  assign w_up_sum   = {1'b0, r_duty}    + {1'b0, r_cfg.step_eff};
  assign w_dn_floor = {1'b0, r_cfg.min} + {1'b0, r_cfg.step_eff};

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_hold_nxt  = r_hold_cnt;
    w_cfg_nxt   = r_cfg;
    w_done_nxt  = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        ST_IDLE: if (en) begin
          w_cfg_nxt   = w_cfg_new;
          w_duty_nxt  = w_cfg_new.min;
          w_state_nxt = ST_UP;
        end
        ST_UP: if (!en) begin
          w_state_nxt = ST_IDLE;
          w_duty_nxt  = '0;
        end else if (w_up_sum >= {1'b0, r_cfg.max_eff}) begin
          w_duty_nxt  = r_cfg.max_eff;
          w_hold_nxt  = '0;
          w_state_nxt = ST_HOLD_HI;
        end else begin
          w_duty_nxt  = w_up_sum[R-1:0];
        end
        ST_HOLD_HI: if (!en) begin
          w_state_nxt = ST_IDLE;
          w_duty_nxt  = '0;
        end else if (r_hold_cnt == r_cfg.hold) begin
          w_state_nxt = ST_DOWN;
        end else begin
          w_hold_nxt  = r_hold_cnt + H'(1);
        end
        ST_DOWN: if (!en) begin
          w_state_nxt = ST_IDLE;
          w_duty_nxt  = '0;
        end else if ({1'b0, r_duty} <= w_dn_floor) begin
          w_duty_nxt  = r_cfg.min;
          w_hold_nxt  = '0;
          w_state_nxt = ST_HOLD_LO;
        end else begin
          w_duty_nxt  = r_duty - r_cfg.step_eff;
        end
        ST_HOLD_LO: if (r_hold_cnt == r_cfg.hold) begin
          w_done_nxt = 1'b1;
          if (en) begin
            w_cfg_nxt   = w_cfg_new;
            w_duty_nxt  = w_cfg_new.min;
            w_state_nxt = ST_UP;
          end else begin
            w_duty_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_hold_nxt = r_hold_cnt + H'(1);
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_duty_nxt  = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_duty       <= '0;
      r_hold_cnt   <= '0;
      r_cfg        <= '0;
      r_cycle_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_duty       <= w_duty_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_cfg        <= w_cfg_nxt;
      r_cycle_done <= w_done_nxt;
    end
  end

  assign duty        = r_duty;
  assign state       = r_state;
  assign busy        = (r_state != ST_IDLE);
  assign cycle_done  = r_cycle_done;
  assign period_tick = w_tick;

endmodule
